// File: rtl/rs_branch.sv
// rs_branch: branch-FU reservation station (collapsing queue, wakeup, oldest-ready issue, mispredict squash)
//
// Ports:
//   clk_i            clock, all state updates on posedge
//   reset_i          synchronous active-low reset
//   disp_valid_i     dispatch a branch this cycle
//   disp_data_i      renamed uop to buffer
//   disp_ps1_rdy_i   ps1 already valid in the PRF at dispatch
//   disp_ps2_rdy_i   ps2 already valid in the PRF at dispatch
//   disp_ready_o     station can take a dispatch (count < DEPTH)
//   wb_valid_i       per-bus writeback valid
//   wb_preg_i        per-bus written physical register, bus i at [i*PREG_W +: PREG_W]
//   fu_b_ready_i     fu_branch can accept an issue
//   curr_rob_tag_i   ROB tail (next tag to allocate)
//   mispredict_i     mispredict/redirect this cycle
//   mispredict_tag_i ROB tag of the mispredicting branch
//   issued_o         registered issue-slot valid
//   data_out_o       registered issued uop
//   count_o          number of occupied entries
package rs_branch_pkg;
   typedef struct packed {
      logic [4:0]  rob_index;
      logic [6:0]  ps1;
      logic [6:0]  ps2;
      logic [6:0]  pd;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [6:0]  opcode;
      logic [2:0]  func3;
   } rs_data_t;
endpackage

module rs_branch
   import rs_branch_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int PREG_W    = 7,
   parameter int NUM_WB    = 3,
   parameter int ROB_DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       disp_valid_i,
   input  rs_data_t                   disp_data_i,
   input  logic                       disp_ps1_rdy_i,
   input  logic                       disp_ps2_rdy_i,
   output logic                       disp_ready_o,
   input  logic [NUM_WB-1:0]          wb_valid_i,
   input  logic [NUM_WB*PREG_W-1:0]   wb_preg_i,
   input  logic                       fu_b_ready_i,
   input  logic [4:0]                 curr_rob_tag_i,
   input  logic                       mispredict_i,
   input  logic [4:0]                 mispredict_tag_i,
   output logic                       issued_o,
   output rs_data_t                   data_out_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(DEPTH);
   localparam int TW = $clog2(ROB_DEPTH);
   logic [DEPTH-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
   rs_data_t         uop_q [DEPTH];
   rs_data_t         uop_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             issued_q;
   rs_data_t         data_q;
   logic             sel_vld;
   logic [IW-1:0]    sel_idx;
   logic             accept;
   // A register counts as ready if it is x0 or any writeback bus writes it this cycle.
   function automatic logic woken(input logic [PREG_W-1:0] p);
      woken = (p == '0);
      for (int i = 0; i < NUM_WB; i++)
         if (wb_valid_i[i] && wb_preg_i[i*PREG_W +: PREG_W] == p) woken = 1'b1;
   endfunction
   // Squash window is [mispredict_tag+1, curr_rob_tag) mod ROB_DEPTH: compare offsets from its start.
   function automatic logic squash(input logic [4:0] rob);
      logic [TW-1:0] lo, off, len;
      lo  = mispredict_tag_i[TW-1:0] + TW'(1);
      off = rob[TW-1:0] - lo;
      len = curr_rob_tag_i[TW-1:0] - lo;
      squash = off < len;
   endfunction
   assign disp_ready_o = count_q < CW'(DEPTH);
   assign issued_o     = issued_q;
   assign data_out_o   = data_q;
   assign count_o      = count_q;
   // Descending scan so the lowest (oldest) ready position wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
            sel_vld = fu_b_ready_i && !mispredict_i;
            sel_idx = IW'(i);
         end
   end
   // Survivors are packed down in age order, then the dispatched uop lands just above them.
   always_comb begin
      logic [CW-1:0] ptr;
      ptr     = '0;
      valid_d = '0;
      rdy1_d  = '0;
      rdy2_d  = '0;
      for (int i = 0; i < DEPTH; i++) uop_d[i] = '0;
      for (int i = 0; i < DEPTH; i++)
         if (valid_q[i] && !(sel_vld && sel_idx == IW'(i)) && !(mispredict_i && squash(uop_q[i].rob_index))) begin
            valid_d[ptr[IW-1:0]] = 1'b1;
            uop_d[ptr[IW-1:0]]   = uop_q[i];
            rdy1_d[ptr[IW-1:0]]  = rdy1_q[i] | woken(uop_q[i].ps1);
            rdy2_d[ptr[IW-1:0]]  = rdy2_q[i] | woken(uop_q[i].ps2);
            ptr = ptr + CW'(1);
         end
      accept = disp_valid_i && disp_ready_o && !mispredict_i;
      if (accept) begin
         valid_d[ptr[IW-1:0]] = 1'b1;
         uop_d[ptr[IW-1:0]]   = disp_data_i;
         rdy1_d[ptr[IW-1:0]]  = disp_ps1_rdy_i | woken(disp_data_i.ps1);
         rdy2_d[ptr[IW-1:0]]  = disp_ps2_rdy_i | woken(disp_data_i.ps2);
         ptr = ptr + CW'(1);
      end
      count_d = ptr;
   end
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         valid_q  <= '0;
         rdy1_q   <= '0;
         rdy2_q   <= '0;
         count_q  <= '0;
         issued_q <= 1'b0;
         data_q   <= '0;
      end else begin
         valid_q  <= valid_d;
         rdy1_q   <= rdy1_d;
         rdy2_q   <= rdy2_d;
         uop_q    <= uop_d;
         count_q  <= count_d;
         issued_q <= sel_vld;
         if (sel_vld) data_q <= uop_q[sel_idx];
      end
   end
endmodule
